rv_tag_alloc_arbiter: RTL and testbench

RV_TAG_ALLOC_ARBITER -- requirements
Module: RV_tag_alloc_arbiter

---
 rtl/rv_tag_alloc_arbiter_pkg.sv | 25 ++
 rtl/rv_tag_alloc_arbiter_rr_arbiter.sv | 52 +++++
 rtl/rv_tag_alloc_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rv_tag_alloc_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_tag_alloc_arbiter_pkg.sv
// Shared definitions for the tag allocation arbiter: default depth limits,
// width derivations and the release classification type.
package rv_tag_alloc_arbiter_pkg;

  // Outstanding slots a single requester may hold by default
  localparam int unsigned MAX_PEND_DEFAULT = 2;

  // Requester-id width; never narrower than one bit
  function automatic int unsigned calc_reqw(input int unsigned num_reqs);
    return (num_reqs > 1) ? 32'($clog2(num_reqs)) : 32'd1;
  endfunction

  // Counter width able to hold the value 0..max_val inclusive
  function automatic int unsigned calc_cntw(input int unsigned max_val);
    return 32'($clog2(max_val + 1));
  endfunction

  // Outcome of a release request in the current cycle
  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_LEGAL   = 2'd1,
    REL_ILLEGAL = 2'd2
  } rel_kind_e;

endpackage

// File: rtl/rv_tag_alloc_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter. The search starts at an internal pointer that
// moves just past the winner; with no grant the pointer holds.
module rv_tag_alloc_arbiter_rr_arbiter
  import rv_tag_alloc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned REQW     = calc_reqw(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_REQS-1:0] req,
  output logic [NUM_REQS-1:0] grant,
  output logic [REQW-1:0]     grant_idx,
  output logic                grant_valid
);

  logic [REQW-1:0] rr_ptr;

  // First requesting index at or after rr_ptr, wrapping around
  always_comb begin
    int unsigned     idx;
    logic [REQW-1:0] sel;
    idx         = 0;
    sel         = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQS; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end
      sel = REQW'(idx);
      if (enable && !grant_valid && req[sel]) begin
        grant[sel]  = 1'b1;
        grant_idx   = sel;
        grant_valid = 1'b1;
      end
    end
  end

  // Pointer advances to the slot after the winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == REQW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rv_tag_alloc_arbiter.sv
// Tag allocator in front of an index buffer: arbitrates requesters for free
// slots, limits per-requester outstanding slots, tracks slot ownership and
// filters releases of slots that are not allocated.
module rv_tag_alloc_arbiter
  import rv_tag_alloc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 8,
  parameter int unsigned SIZE     = 4,
  parameter int unsigned MAX_PEND = MAX_PEND_DEFAULT,
  parameter int unsigned ADDRW    = $clog2(SIZE),
  parameter int unsigned REQW     = calc_reqw(NUM_REQS),
  parameter int unsigned CNTW     = calc_cntw(SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      rsp_valid,
  output logic [ADDRW-1:0]          rsp_tag,
  output logic [REQW-1:0]           rsp_reqid,
  input  logic                      rel_valid,
  input  logic [ADDRW-1:0]          rel_tag,
  output logic                      ib_acquire,
  output logic [DATAW-1:0]          ib_wdata,
  input  logic [ADDRW-1:0]          ib_waddr,
  output logic                      ib_release,
  output logic [ADDRW-1:0]          ib_release_addr,
  output logic [CNTW-1:0]           occupancy,
  output logic                      rel_err
);

  localparam int unsigned PENDW = calc_cntw(MAX_PEND);

  logic [SIZE-1:0]     alloc_map;
  logic [SIZE-1:0]     alloc_map_d;
  logic [REQW-1:0]     owner    [SIZE];
  logic [PENDW-1:0]    pend_cnt [NUM_REQS];
  logic [PENDW-1:0]    pend_d   [NUM_REQS];
  logic [CNTW-1:0]     occupancy_d;
  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] grant;
  logic [REQW-1:0]     grant_idx;
  logic                grant_valid;
  rel_kind_e           rel_kind;
  logic                rel_legal;
  logic [REQW-1:0]     rel_owner;
  logic                slot_clash;
  logic                has_room;
  logic                arb_enable;

  // Classify the release: only allocated slots may be freed
  always_comb begin
    rel_kind = REL_NONE;
    if (rel_valid) begin
      rel_kind = alloc_map[rel_tag] ? REL_LEGAL : REL_ILLEGAL;
    end
  end

  assign rel_legal = (rel_kind == REL_LEGAL);
  assign rel_owner = owner[rel_tag];

  // A slot being released cannot be handed out in the same cycle; the
  // grant waits for the index buffer to re-report it as free
  assign slot_clash = rel_legal && (rel_tag == ib_waddr);
  assign has_room   = (occupancy < CNTW'(SIZE));
  assign arb_enable = reset && has_room && !slot_clash;

  // Per-requester eligibility against the outstanding-slot limit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (pend_cnt[i] < PENDW'(MAX_PEND));
    end
  end

  rv_tag_alloc_arbiter_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .REQW     (REQW)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .enable      (arb_enable),
    .req         (eligible),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready       = grant;
  assign ib_acquire      = grant_valid;
  assign ib_release      = reset && rel_legal;
  assign ib_release_addr = rel_tag;

  // Forward the granted requester's payload to the index buffer
  always_comb begin
    ib_wdata = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        ib_wdata = req_data[i*DATAW +: DATAW];
      end
    end
  end

  // Allocation map: clear released slot, mark newly granted slot
  always_comb begin
    alloc_map_d = alloc_map;
    if (rel_legal) begin
      alloc_map_d[rel_tag] = 1'b0;
    end
    if (grant_valid) begin
      alloc_map_d[ib_waddr] = 1'b1;
    end
  end

  // Outstanding counts: grant and release to the same requester cancel
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_d[i] = pend_cnt[i];
      inc       = grant[i];
      dec       = rel_legal && (rel_owner == REQW'(i));
      if (inc && !dec && (pend_cnt[i] < PENDW'(MAX_PEND))) begin
        pend_d[i] = pend_cnt[i] + 1'b1;
      end else if (dec && !inc && (pend_cnt[i] != '0)) begin
        pend_d[i] = pend_cnt[i] - 1'b1;
      end
    end
  end

  // Occupancy: saturating at both ends, unchanged when grant and release pair up
  always_comb begin
    occupancy_d = occupancy;
    if (grant_valid && !rel_legal && (occupancy < CNTW'(SIZE))) begin
      occupancy_d = occupancy + 1'b1;
    end else if (rel_legal && !grant_valid && (occupancy != '0)) begin
      occupancy_d = occupancy - 1'b1;
    end
  end

  // Slot bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_map <= '0;
      occupancy <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend_cnt[i] <= '0;
      end
      for (int s = 0; s < SIZE; s++) begin
        owner[s] <= '0;
      end
    end else begin
      alloc_map <= alloc_map_d;
      occupancy <= occupancy_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend_cnt[i] <= pend_d[i];
      end
      if (grant_valid) begin
        owner[ib_waddr] <= grant_idx;
      end
    end
  end

  // Tag return one cycle after the grant, and the illegal-release pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_reqid <= '0;
      rel_err   <= 1'b0;
    end else begin
      rsp_valid <= grant_valid;
      if (grant_valid) begin
        rsp_tag   <= ib_waddr;
        rsp_reqid <= grant_idx;
      end
      rel_err <= (rel_kind == REL_ILLEGAL);
    end
  end

endmodule

// File: tb/tb_rv_tag_alloc_arbiter.sv
// Directed bench for rv_tag_alloc_arbiter with a tag-return scoreboard and a
// small index-buffer stub that reports the lowest free slot.
module tb_rv_tag_alloc_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_tag;
  logic [1:0]  rsp_reqid;
  logic        rel_valid;
  logic [1:0]  rel_tag;
  logic        ib_acquire;
  logic [7:0]  ib_wdata;
  logic [1:0]  ib_waddr;
  logic        ib_release;
  logic [1:0]  ib_release_addr;
  logic [2:0]  occupancy;
  logic        rel_err;

  logic [3:0]  ib_map;
  logic        ib_force;
  logic [1:0]  ib_force_val;

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [1:0] tag;
    logic [1:0] reqid;
  } rsp_t;

  rsp_t exp_rsp_q[$];
  bit   exp_err_q[$];

  rv_tag_alloc_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_tag         (rsp_tag),
    .rsp_reqid       (rsp_reqid),
    .rel_valid       (rel_valid),
    .rel_tag         (rel_tag),
    .ib_acquire      (ib_acquire),
    .ib_wdata        (ib_wdata),
    .ib_waddr        (ib_waddr),
    .ib_release      (ib_release),
    .ib_release_addr (ib_release_addr),
    .occupancy       (occupancy),
    .rel_err         (rel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [1:0] lowest_free(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Index-buffer stub
  assign ib_waddr = ib_force ? ib_force_val : lowest_free(ib_map);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ib_map <= 4'b0000;
    end else begin
      if (ib_acquire) ib_map[ib_waddr] <= 1'b1;
      if (ib_release) ib_map[ib_release_addr] <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic exp_rsp(input logic [1:0] tag, input logic [1:0] reqid);
    rsp_t e;
    e.tag   = tag;
    e.reqid = reqid;
    exp_rsp_q.push_back(e);
  endtask

  // Monitor: compare every returned tag and every error pulse
  always @(negedge clk) begin
    rsp_t e;
    bit   b;
    if (rsp_valid === 1'b1) begin
      if (exp_rsp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got tag %0d reqid %0d expected no response", rsp_tag, rsp_reqid);
      end else begin
        e = exp_rsp_q.pop_front();
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_reqid", 32'(rsp_reqid), 32'(e.reqid));
      end
    end
    if (rel_err === 1'b1) begin
      if (exp_err_q.size() == 0) begin
        n_checks++;
        $display("FAIL rel_err_unexpected: got 1 expected 0");
      end else begin
        b = exp_err_q.pop_front();
        chk("rel_err", 32'(rel_err), 32'(b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic rel, input logic [1:0] rt);
    req_valid = rv;
    rel_valid = rel;
    rel_tag   = rt;
    #1;
  endtask

  // Assert reset mid-cycle with stimulus active, check gating, then release
  task automatic do_reset();
    step();
    reset     = 1'b0;
    req_valid = 4'hF;
    rel_valid = 1'b1;
    rel_tag   = 2'd1;
    ib_force  = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ib_acquire", 32'(ib_acquire), 32'h0);
    chk("rst_ib_release", 32'(ib_release), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rel_err", 32'(rel_err), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    step();
    req_valid = 4'h0;
    rel_valid = 1'b0;
    reset     = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    req_valid    = 4'h0;
    rel_valid    = 1'b0;
    rel_tag      = 2'd0;
    ib_force     = 1'b0;
    ib_force_val = 2'd0;
    req_data     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    do_reset();

    // Single request from requester 0
    step(); drive(4'b0001, 1'b0, 2'd0);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_acquire", 32'(ib_acquire), 32'h1);
    chk("single_wdata", 32'(ib_wdata), 32'hA0);
    exp_rsp(2'd0, 2'd0);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("single_occ", 32'(occupancy), 32'h1);
    chk("single_acq_idle", 32'(ib_acquire), 32'h0);
    step();

    do_reset();

    // All four requesting: round-robin fills the buffer in order
    for (int k = 0; k < 4; k++) begin
      step(); drive(4'hF, 1'b0, 2'd0);
      chk("burst_ready", 32'(req_ready), 32'(4'b0001 << k));
      chk("burst_wdata", 32'(ib_wdata), 32'(8'hA0 + k));
      exp_rsp(2'(k), 2'(k));
    end
    step(); drive(4'hF, 1'b0, 2'd0);
    chk("burst_full_ready", 32'(req_ready), 32'h0);
    chk("burst_occ", 32'(occupancy), 32'h4);

    // Full buffer: release tag 1 while requester 0 asks
    step(); drive(4'b0001, 1'b1, 2'd1);
    chk("full_rel_fwd", 32'(ib_release), 32'h1);
    chk("full_rel_addr", 32'(ib_release_addr), 32'h1);
    chk("full_rel_ready", 32'(req_ready), 32'h0);
    step(); drive(4'b0001, 1'b0, 2'd0);
    chk("after_rel_occ", 32'(occupancy), 32'h3);
    chk("after_rel_ready", 32'(req_ready), 32'h1);
    exp_rsp(2'd1, 2'd0);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("refill_occ", 32'(occupancy), 32'h4);

    // Release tag 2 alone, then grant and release together
    step(); drive(4'b0000, 1'b1, 2'd2);
    chk("rel2_fwd", 32'(ib_release), 32'h1);
    step(); drive(4'b0100, 1'b1, 2'd3);
    chk("dual_ready", 32'(req_ready), 32'h4);
    chk("dual_rel_fwd", 32'(ib_release), 32'h1);
    chk("dual_occ_before", 32'(occupancy), 32'h3);
    exp_rsp(2'd2, 2'd2);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("dual_occ_after", 32'(occupancy), 32'h3);

    // Illegal release of free slot 3
    step(); drive(4'b0000, 1'b1, 2'd3);
    chk("illegal_no_fwd", 32'(ib_release), 32'h0);
    exp_err_q.push_back(1'b1);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("illegal_occ", 32'(occupancy), 32'h3);

    // Release of the slot the buffer is reporting as next free
    step();
    ib_force     = 1'b1;
    ib_force_val = 2'd0;
    drive(4'b0010, 1'b1, 2'd0);
    chk("clash_ready", 32'(req_ready), 32'h0);
    chk("clash_acquire", 32'(ib_acquire), 32'h0);
    chk("clash_rel_fwd", 32'(ib_release), 32'h1);
    step();
    ib_force = 1'b0;
    drive(4'b0010, 1'b0, 2'd0);
    chk("clash_next_ready", 32'(req_ready), 32'h2);
    chk("clash_next_occ", 32'(occupancy), 32'h2);
    exp_rsp(2'd0, 2'd1);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("clash_final_occ", 32'(occupancy), 32'h3);
    step();

    do_reset();

    // Requester 2 alone hits its outstanding limit
    step(); drive(4'b0100, 1'b0, 2'd0);
    chk("pend_g1", 32'(req_ready), 32'h4);
    exp_rsp(2'd0, 2'd2);
    step(); drive(4'b0100, 1'b0, 2'd0);
    chk("pend_g2", 32'(req_ready), 32'h4);
    exp_rsp(2'd1, 2'd2);
    step(); drive(4'b0100, 1'b0, 2'd0);
    chk("pend_block1", 32'(req_ready), 32'h0);
    step(); drive(4'b0100, 1'b0, 2'd0);
    chk("pend_block2", 32'(req_ready), 32'h0);
    step(); drive(4'b0100, 1'b1, 2'd0);
    chk("pend_rel_ready", 32'(req_ready), 32'h0);
    chk("pend_rel_fwd", 32'(ib_release), 32'h1);
    step(); drive(4'b0100, 1'b0, 2'd0);
    chk("pend_regrant", 32'(req_ready), 32'h4);
    exp_rsp(2'd0, 2'd2);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("pend_occ", 32'(occupancy), 32'h2);

    // Third slot, then reset mid-operation
    step(); drive(4'b0001, 1'b0, 2'd0);
    chk("pre_rst_ready", 32'(req_ready), 32'h1);
    exp_rsp(2'd2, 2'd0);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("pre_rst_occ", 32'(occupancy), 32'h3);
    do_reset();

    step(); drive(4'b1000, 1'b0, 2'd0);
    chk("post_rst_occ", 32'(occupancy), 32'h0);
    chk("post_rst_ready", 32'(req_ready), 32'h8);
    exp_rsp(2'd0, 2'd3);
    step(); drive(4'b0000, 1'b0, 2'd0);
    chk("post_rst_occ1", 32'(occupancy), 32'h1);
    step();
    step();

    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'h0);
    chk("err_queue_drained", 32'(exp_err_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
